dsp_cmd_sequencer: RTL and testbench

Command-driven initiator for the DSP_TOP (DSP48A1-style) slice. It accepts one operation per valid/ready handshake and drives the slice's operand, opmode, clock-enable and reset inputs. It holds operands stable for exactly the configured pipeline depth, then captures P, M and CARRYOUT and returns them on a valid/ready response channel. It sits between control logic and the DSP_TOP instance, and replaces hand-timed stimulus with a cycle-exact driver.

---
 rtl/dsp_cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_dsp_cmd_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_cmd_sequencer.sv
// dsp_cmd_sequencer: accepts one DSP operation per cmd handshake, drives the DSP_TOP
// operand/opmode/CE/RST inputs for a fixed number of enabled edges, then returns the
// captured P, M and CARRYOUT on the rsp handshake channel.
module dsp_cmd_sequencer #(
    parameter int unsigned LATENCY = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    // command channel
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_clear,
    input  logic [7:0]  cmd_opmode,
    input  logic [17:0] cmd_a,
    input  logic [17:0] cmd_b,
    input  logic [47:0] cmd_c,
    input  logic [17:0] cmd_d,
    input  logic        cmd_carryin,
    // response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [47:0] rsp_p,
    output logic [35:0] rsp_m,
    output logic        rsp_carryout,
    // DSP slice side
    output logic [7:0]  dsp_opmode,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [47:0] dsp_c,
    output logic [17:0] dsp_d,
    output logic        dsp_carryin,
    output logic        dsp_ce,
    output logic        dsp_rst,
    input  logic [47:0] dsp_p,
    input  logic [35:0] dsp_m,
    input  logic        dsp_carryout
);

    typedef enum logic [1:0] {StIdle, StRun, StClr, StResp} state_t;

    localparam logic [3:0] LatCnt = 4'(LATENCY);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        init_q;
    logic        load_ops;
    logic        cap;
    logic        cap_zero;
    logic        rst_cmd;

    // State, counter and the post-reset ready gate
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= 1'b1;
        end
    end

    // Next-state and handshake/DSP control decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_ops  = 1'b0;
        cap       = 1'b0;
        cap_zero  = 1'b0;
        cmd_ready = 1'b0;
        dsp_ce    = 1'b0;
        rst_cmd   = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = init_q;
                if (cmd_valid && init_q) begin
                    if (cmd_clear) begin
                        state_d = StClr;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d  = StRun;
                        cnt_d    = LatCnt;
                        load_ops = 1'b1;
                    end
                end
            end
            StRun: begin
                // CE spans LATENCY edges; the edge after the last enabled one captures P
                if (cnt_q != 4'd0) begin
                    dsp_ce = 1'b1;
                    cnt_d  = cnt_q - 4'd1;
                end else begin
                    cap     = 1'b1;
                    state_d = StResp;
                end
            end
            StClr: begin
                // One cycle of DSP reset, then one settle cycle before responding
                if (cnt_q != 4'd0) begin
                    rst_cmd = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    cap_zero = 1'b1;
                    state_d  = StResp;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // The DSP pipeline clears together with the sequencer
    assign dsp_rst = !RST_N || rst_cmd;

    // Operand registers, changed only on accept of a compute command
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dsp_opmode  <= 8'd0;
            dsp_a       <= 18'd0;
            dsp_b       <= 18'd0;
            dsp_c       <= 48'd0;
            dsp_d       <= 18'd0;
            dsp_carryin <= 1'b0;
        end else if (load_ops) begin
            dsp_opmode  <= cmd_opmode;
            dsp_a       <= cmd_a;
            dsp_b       <= cmd_b;
            dsp_c       <= cmd_c;
            dsp_d       <= cmd_d;
            dsp_carryin <= cmd_carryin;
        end
    end

    // Result capture; a clear command returns an all-zero response
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rsp_p        <= 48'd0;
            rsp_m        <= 36'd0;
            rsp_carryout <= 1'b0;
        end else if (cap) begin
            rsp_p        <= dsp_p;
            rsp_m        <= dsp_m;
            rsp_carryout <= dsp_carryout;
        end else if (cap_zero) begin
            rsp_p        <= 48'd0;
            rsp_m        <= 36'd0;
            rsp_carryout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_cmd_sequencer.sv
// Bench for dsp_cmd_sequencer: a pipelined DSP_TOP stand-in, a timeline model of the
// expected handshake/CE/RST behaviour checked every cycle, and directed scenarios.
module tb_dsp_cmd_sequencer;

    localparam int L = 4;

    logic        CLK;
    logic        RST_N;
    logic        cmd_valid, cmd_ready, cmd_clear, cmd_carryin;
    logic [7:0]  cmd_opmode;
    logic [17:0] cmd_a, cmd_b, cmd_d;
    logic [47:0] cmd_c;
    logic        rsp_valid, rsp_ready, rsp_carryout;
    logic [47:0] rsp_p;
    logic [35:0] rsp_m;
    logic [7:0]  dsp_opmode;
    logic [17:0] dsp_a, dsp_b, dsp_d;
    logic [47:0] dsp_c;
    logic        dsp_carryin, dsp_ce, dsp_rst;
    logic [47:0] dsp_p;
    logic [35:0] dsp_m;
    logic        dsp_carryout;

    int checks = 0;
    int errors = 0;

    dsp_cmd_sequencer #(.LATENCY(L)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_clear    (cmd_clear),
        .cmd_opmode   (cmd_opmode),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_c        (cmd_c),
        .cmd_d        (cmd_d),
        .cmd_carryin  (cmd_carryin),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_p        (rsp_p),
        .rsp_m        (rsp_m),
        .rsp_carryout (rsp_carryout),
        .dsp_opmode   (dsp_opmode),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_c        (dsp_c),
        .dsp_d        (dsp_d),
        .dsp_carryin  (dsp_carryin),
        .dsp_ce       (dsp_ce),
        .dsp_rst      (dsp_rst),
        .dsp_p        (dsp_p),
        .dsp_m        (dsp_m),
        .dsp_carryout (dsp_carryout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // DSP arithmetic: returns {carryout, P, M}
    function automatic logic [84:0] dsp_calc(input logic [7:0] op, input logic [17:0] a,
                                             input logic [17:0] b, input logic [17:0] d,
                                             input logic [47:0] c, input logic cin,
                                             input logic [47:0] pfb);
        logic [17:0] pre;
        logic [35:0] m;
        logic [47:0] x, z;
        logic [48:0] s;
        pre = (op[6] && op[4]) ? d - b : d + b;
        m   = {18'd0, pre} * {18'd0, a};
        case (op[1:0])
            2'd0:    x = 48'd0;
            2'd1:    x = {12'd0, m};
            2'd2:    x = pfb;
            default: x = {d[11:0], a, b};
        endcase
        case (op[3:2])
            2'd2:    z = pfb;
            2'd3:    z = c;
            default: z = 48'd0;
        endcase
        if (op[7]) s = {1'b0, z} - ({1'b0, x} + 49'(cin));
        else       s = {1'b0, z} + {1'b0, x} + 49'(cin);
        return {s[48], s[47:0], m};
    endfunction

    // DSP_TOP stand-in: result emerges after L enabled edges
    logic [84:0] st [L];
    always @(posedge CLK) begin
        if (dsp_rst) begin
            for (int i = 0; i < L; i++) st[i] <= '0;
        end else if (dsp_ce) begin
            st[0] <= dsp_calc(dsp_opmode, dsp_a, dsp_b, dsp_d, dsp_c, dsp_carryin, dsp_p);
            for (int i = 1; i < L; i++) st[i] <= st[i-1];
        end
    end
    assign dsp_carryout = st[L-1][84];
    assign dsp_p        = st[L-1][83:36];
    assign dsp_m        = st[L-1][35:0];

    // Edge counters used by the directed checks
    int ce_total = 0;
    int rst_total = 0;
    always @(posedge CLK) begin
        if (RST_N && dsp_ce)  ce_total  <= ce_total + 1;
        if (RST_N && dsp_rst) rst_total <= rst_total + 1;
    end

    // Timeline model: everything is derived from the accept cycle index
    int          m_k, m_acc;
    logic        m_init, m_busy, m_clear;
    logic [7:0]  m_op;
    logic [17:0] m_a, m_b, m_d;
    logic [47:0] m_c;
    logic        m_cin;
    logic [84:0] m_res;
    logic        exp_ready, exp_valid, exp_ce, exp_rst;

    always_comb begin
        exp_ready = m_init && !m_busy;
        exp_ce    = m_busy && !m_clear && (m_k >= m_acc) && (m_k <= m_acc + L - 1);
        exp_rst   = !RST_N || (m_busy && m_clear && (m_k == m_acc));
        exp_valid = m_busy && (m_clear ? (m_k >= m_acc + 2) : (m_k >= m_acc + L + 1));
    end

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_k <= 0; m_acc <= 0; m_init <= 1'b0; m_busy <= 1'b0; m_clear <= 1'b0;
            m_op <= '0; m_a <= '0; m_b <= '0; m_c <= '0; m_d <= '0; m_cin <= 1'b0;
            m_res <= '0;
        end else begin
            m_k    <= m_k + 1;
            m_init <= 1'b1;
            if (exp_ready && cmd_valid) begin
                m_busy  <= 1'b1;
                m_clear <= cmd_clear;
                m_acc   <= m_k + 1;
                if (cmd_clear) begin
                    m_res <= '0;
                end else begin
                    m_op <= cmd_opmode; m_a <= cmd_a; m_b <= cmd_b;
                    m_c <= cmd_c; m_d <= cmd_d; m_cin <= cmd_carryin;
                    m_res <= dsp_calc(cmd_opmode, cmd_a, cmd_b, cmd_d, cmd_c, cmd_carryin,
                                      48'd0);
                end
            end else if (exp_valid && rsp_ready) begin
                m_busy <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge CLK) begin
        chk("cmd_ready", 128'(cmd_ready), 128'(exp_ready));
        chk("rsp_valid", 128'(rsp_valid), 128'(exp_valid));
        chk("dsp_ce", 128'(dsp_ce), 128'(exp_ce));
        chk("dsp_rst", 128'(dsp_rst), 128'(exp_rst));
        chk("dsp_operands", {dsp_opmode, dsp_a, dsp_b, dsp_c, dsp_d, dsp_carryin},
            {m_op, m_a, m_b, m_c, m_d, m_cin});
        if (!RST_N) begin
            chk("rsp_in_reset", {rsp_carryout, rsp_p, rsp_m}, 128'd0);
        end else if (exp_valid) begin
            chk("rsp_data", {rsp_carryout, rsp_p, rsp_m}, 128'(m_res));
        end
    end

    task automatic set_cmd(input logic clr, input logic [7:0] op, input logic [17:0] a,
                           input logic [17:0] b, input logic [47:0] c, input logic [17:0] d);
        cmd_clear = clr; cmd_opmode = op; cmd_a = a; cmd_b = b; cmd_c = c; cmd_d = d;
        cmd_carryin = 1'b0;
        cmd_valid = 1'b1;
    endtask

    // Offer the command and return just after the accept edge
    task automatic send(input logic clr, input logic [7:0] op, input logic [17:0] a,
                        input logic [17:0] b, input logic [47:0] c, input logic [17:0] d);
        bit done = 0;
        set_cmd(clr, op, a, b, c, d);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            if (cmd_ready) begin
                @(posedge CLK);
                #2 cmd_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) chk("accept_timeout", 128'd0, 128'd1);
    endtask

    // Count edges until rsp_valid is seen
    task automatic wait_rsp(output int lat);
        bit done = 0;
        lat = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge CLK);
            lat++;
            #1;
            if (rsp_valid) done = 1;
        end
        if (!done) chk("rsp_timeout", 128'd0, 128'd1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge CLK);
        #2 rsp_ready = 1'b0;
    endtask

    int lat, ce0, rst0;

    initial begin
        RST_N = 1'b0;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_carryin = $urandom_range(0, 1);
        cmd_opmode = 8'($urandom); cmd_a = 18'($urandom); cmd_b = 18'($urandom);
        cmd_c = {16'($urandom), 32'($urandom)}; cmd_d = 18'($urandom);

        // Reset behaviour
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_cmd_ready", 128'(cmd_ready), 128'd0);
        chk("reset_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("reset_dsp_ce", 128'(dsp_ce), 128'd0);
        chk("reset_dsp_rst", 128'(dsp_rst), 128'd1);
        @(posedge CLK);
        #2 RST_N = 1'b1; cmd_valid = 1'b0;
        @(posedge CLK);
        #1 chk("ready_after_reset", 128'(cmd_ready), 128'd1);

        // Path test
        ce0 = ce_total;
        send(1'b0, 8'b11011101, 18'd20, 18'd10, 48'd350, 18'd25);
        wait_rsp(lat);
        chk("path_latency", 128'(lat), 128'd5);
        chk("path_ce_edges", 128'(ce_total - ce0), 128'd4);
        chk("path_p", 128'(rsp_p), 128'h32);
        chk("path_m", 128'(rsp_m), 128'h12c);
        chk("path_co", 128'(rsp_carryout), 128'd0);
        ack();

        // Opmode with no post-adder inputs
        send(1'b0, 8'b00010000, 18'd20, 18'd10, 48'd350, 18'd25);
        wait_rsp(lat);
        chk("op2_p", 128'(rsp_p), 128'd0);
        chk("op2_m", 128'(rsp_m), 128'h2bc);
        chk("op2_co", 128'(rsp_carryout), 128'd0);
        ack();

        // Clear after a nonzero result
        rst0 = rst_total;
        send(1'b1, 8'hff, 18'h3ffff, 18'h3ffff, 48'hffff, 18'h3ffff);
        wait_rsp(lat);
        chk("clr_latency", 128'(lat), 128'd2);
        chk("clr_rst_edges", 128'(rst_total - rst0), 128'd1);
        chk("clr_rsp", {rsp_carryout, rsp_p, rsp_m}, 128'd0);
        ack();

        // Backpressure with a pending command offered throughout
        send(1'b0, 8'b11011101, 18'd20, 18'd10, 48'd350, 18'd25);
        wait_rsp(lat);
        set_cmd(1'b0, 8'b00010000, 18'd20, 18'd10, 48'd350, 18'd25);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("bp_valid", 128'(rsp_valid), 128'd1);
            chk("bp_p", 128'(rsp_p), 128'h32);
            chk("bp_ce", 128'(dsp_ce), 128'd0);
            chk("bp_ready", 128'(cmd_ready), 128'd0);
        end
        rsp_ready = 1'b1;
        @(posedge CLK);
        #2 rsp_ready = 1'b0;
        @(negedge CLK);
        chk("bp_ready_after", 128'(cmd_ready), 128'd1);
        @(posedge CLK);
        #2 cmd_valid = 1'b0;
        @(negedge CLK);
        chk("bp_next_running", 128'(dsp_ce), 128'd1);
        wait_rsp(lat);
        chk("bp_next_m", 128'(rsp_m), 128'h2bc);
        ack();

        // Abort mid-RUN, then reissue
        send(1'b0, 8'b11011101, 18'd7, 18'd3, 48'd1000, 18'd9);
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        send(1'b0, 8'b11011101, 18'd20, 18'd10, 48'd350, 18'd25);
        wait_rsp(lat);
        chk("abort_latency", 128'(lat), 128'd5);
        chk("abort_p", 128'(rsp_p), 128'h32);
        ack();
        repeat (3) @(posedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
